// File: rtl/ram_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : ram_arbiter
// Purpose  : Round-robin Wishbone B4 pipelined arbiter sharing one RAM port
//            among NUM_PORTS requesters. Optional macro
//            RAM_ARBITER_CPU_PRIORITY_EN gives port 0 absolute priority.
// Revision : 1.0 - initial release
// ============================================================================
module ram_arbiter #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 17,
    parameter int NUM_PORTS  = 3
) (
    input  logic                            wb_clock_i,
    input  logic                            wb_reset_n_i,
    input  logic [NUM_PORTS*ADDR_WIDTH-1:0] req_addr_i,
    input  logic [NUM_PORTS*DATA_WIDTH-1:0] req_data_i,
    input  logic [NUM_PORTS-1:0]            req_we_i,
    input  logic [NUM_PORTS-1:0]            req_cycle_i,
    input  logic [NUM_PORTS-1:0]            req_strobe_i,
    output logic [NUM_PORTS-1:0]            req_stall_o,
    output logic [NUM_PORTS-1:0]            req_ack_o,
    output logic [DATA_WIDTH-1:0]           req_data_o,
    output logic [ADDR_WIDTH-1:0]           ram_addr_o,
    output logic [DATA_WIDTH-1:0]           ram_data_o,
    output logic                            ram_we_o,
    output logic                            ram_cycle_o,
    output logic                            ram_strobe_o,
    input  logic [DATA_WIDTH-1:0]           ram_data_i,
    input  logic                            ram_stall_i,
    input  logic                            ram_ack_i,
    output logic [NUM_PORTS-1:0]            grant_o
);

    localparam int C_IDX_W = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
    localparam logic [C_IDX_W-1:0] C_LAST_RST = C_IDX_W'(NUM_PORTS - 1);
`ifdef RAM_ARBITER_CPU_PRIORITY_EN
    localparam logic [NUM_PORTS-1:0] C_RR_MASK = ~NUM_PORTS'(1);
`else
    localparam logic [NUM_PORTS-1:0] C_RR_MASK = '1;
`endif

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_ISSUE    = 2'd1,
        ST_ACK_WAIT = 2'd2
    } state_t;

    // Asynchronous assert, two-edge synchronized release.
    logic [1:0] rst_sync_q, rst_sync_d;
    logic       rst_n;

    always_comb rst_sync_d = {rst_sync_q[0], 1'b1};

    always_ff @(posedge wb_clock_i or negedge wb_reset_n_i) begin
        if (!wb_reset_n_i) rst_sync_q <= '0;
        else               rst_sync_q <= rst_sync_d;
    end

    assign rst_n = rst_sync_q[1];

    state_t                 state_q, state_d;
    logic [C_IDX_W-1:0]     last_q, last_d;
    logic [C_IDX_W-1:0]     owner_q, owner_d;
    logic [NUM_PORTS-1:0]   grant_q, grant_d;
    logic [NUM_PORTS-1:0]   ack_q, ack_d;
    logic [DATA_WIDTH-1:0]  rdata_q, rdata_d;
    logic [ADDR_WIDTH-1:0]  ram_addr_q, ram_addr_d;
    logic [DATA_WIDTH-1:0]  ram_data_q, ram_data_d;
    logic                   ram_we_q, ram_we_d;
    logic                   ram_cyc_q, ram_cyc_d;
    logic                   ram_stb_q, ram_stb_d;

    logic [NUM_PORTS-1:0]   req_vld;
    logic [NUM_PORTS-1:0]   rr_req;
    logic                   win_found;
    logic [C_IDX_W-1:0]     win;

    assign req_vld = req_cycle_i & req_strobe_i;
    assign rr_req  = req_vld & C_RR_MASK;

    // Search starts just after the previous owner and wraps.
    always_comb begin
        int                 idx;
        logic [C_IDX_W-1:0] cand;
        idx       = 0;
        cand      = '0;
        win_found = 1'b0;
        win       = '0;
`ifdef RAM_ARBITER_CPU_PRIORITY_EN
        if (req_vld[0]) begin
            win_found = 1'b1;
        end
`endif
        for (int k = 1; k <= NUM_PORTS; k++) begin
            idx  = (int'(last_q) + k) % NUM_PORTS;
            cand = C_IDX_W'(idx);
            if (!win_found && rr_req[cand]) begin
                win_found = 1'b1;
                win       = cand;
            end
        end
    end

    always_comb begin
        req_stall_o = '1;
        if (state_q == ST_IDLE && win_found) req_stall_o[win] = 1'b0;
    end

    always_comb begin
        state_d    = state_q;
        last_d     = last_q;
        owner_d    = owner_q;
        grant_d    = grant_q;
        ack_d      = '0;
        rdata_d    = rdata_q;
        ram_addr_d = ram_addr_q;
        ram_data_d = ram_data_q;
        ram_we_d   = ram_we_q;
        ram_cyc_d  = ram_cyc_q;
        ram_stb_d  = ram_stb_q;
        case (state_q)
            ST_IDLE: begin
                if (win_found) begin
                    ram_addr_d = req_addr_i[int'(win)*ADDR_WIDTH +: ADDR_WIDTH];
                    ram_data_d = req_data_i[int'(win)*DATA_WIDTH +: DATA_WIDTH];
                    ram_we_d   = req_we_i[win];
                    grant_d    = NUM_PORTS'(1) << win;
                    owner_d    = win;
                    ram_cyc_d  = 1'b1;
                    ram_stb_d  = 1'b1;
                    state_d    = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                if (!ram_stall_i) begin
                    ram_stb_d = 1'b0;
                    state_d   = ST_ACK_WAIT;
                end
            end
            ST_ACK_WAIT: begin
                if (ram_ack_i) begin
                    rdata_d   = ram_data_i;
                    // A port that abandoned its cycle gets no ack.
                    ack_d     = grant_q & req_cycle_i;
                    ram_cyc_d = 1'b0;
                    grant_d   = '0;
                    state_d   = ST_IDLE;
`ifdef RAM_ARBITER_CPU_PRIORITY_EN
                    if (owner_q != '0) last_d = owner_q;
`else
                    last_d = owner_q;
`endif
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge wb_clock_i or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            last_q     <= C_LAST_RST;
            owner_q    <= '0;
            grant_q    <= '0;
            ack_q      <= '0;
            rdata_q    <= '0;
            ram_addr_q <= '0;
            ram_data_q <= '0;
            ram_we_q   <= 1'b0;
            ram_cyc_q  <= 1'b0;
            ram_stb_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            last_q     <= last_d;
            owner_q    <= owner_d;
            grant_q    <= grant_d;
            ack_q      <= ack_d;
            rdata_q    <= rdata_d;
            ram_addr_q <= ram_addr_d;
            ram_data_q <= ram_data_d;
            ram_we_q   <= ram_we_d;
            ram_cyc_q  <= ram_cyc_d;
            ram_stb_q  <= ram_stb_d;
        end
    end

    assign req_ack_o    = ack_q;
    assign req_data_o   = rdata_q;
    assign ram_addr_o   = ram_addr_q;
    assign ram_data_o   = ram_data_q;
    assign ram_we_o     = ram_we_q;
    assign ram_cycle_o  = ram_cyc_q;
    assign ram_strobe_o = ram_stb_q;
    assign grant_o      = grant_q;

endmodule
`default_nettype wire
